// File: rtl/fws_pkg.sv
// rtl/fws_pkg.sv - shared state encoding, window geometry and word type for frame_word_server
package fws_pkg;

  localparam int FRAME_ROWS  = 240;
  localparam int FRAME_WORDS = 80;
  localparam int WIN_ROWS    = 80;
  localparam int WIN_WORDS   = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EN    = 2'd1,
    SERVE = 2'd2,
    DRAIN = 2'd3
  } fws_state_e;

  // [3] is the leftmost pixel, [0] the rightmost
  typedef logic [3:0][7:0] pixel_word_t;

endpackage

// File: rtl/fws_frame_ram.sv
// rtl/fws_frame_ram.sv - frame word store, one synchronous write port and one asynchronous read port
module fws_frame_ram
  import fws_pkg::*;
#(
  parameter int DEPTH  = fws_pkg::FRAME_ROWS * fws_pkg::FRAME_WORDS,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_word_t       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output pixel_word_t       rd_data
);

  pixel_word_t mem [DEPTH];

  // Writes past the frame are dropped rather than aliased onto real words.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/frame_word_server.sv
// rtl/frame_word_server.sv - window-origin FSM and combinational word server for the window loader; FWS_BOUNDS_CHECK_EN enables request/read range checks
module frame_word_server #(
  parameter int FRAME_ROWS  = fws_pkg::FRAME_ROWS,
  parameter int FRAME_WORDS = fws_pkg::FRAME_WORDS,
  parameter int WIN_ROWS    = fws_pkg::WIN_ROWS,
  parameter int WIN_WORDS   = fws_pkg::WIN_WORDS,
  parameter int ADDR_W      = $clog2(FRAME_ROWS * FRAME_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              req_valid,
  input  logic [7:0]        req_row,
  input  logic [6:0]        req_col_word,
  output logic              req_ready,
  output logic              en,
  input  logic              ack,
  input  logic [6:0]        row,
  input  logic [6:0]        col,
  output logic [31:0]       input_data,
  input  logic              done,
  output logic              busy,
  output logic              win_done,
  output logic              err
);

  import fws_pkg::*;

  localparam int FRAME_SIZE = FRAME_ROWS * FRAME_WORDS;
  localparam int CALC_W     = ADDR_W + 1;
  localparam int CNT_W      = $clog2(WIN_ROWS * WIN_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WIN_ROWS * WIN_WORDS - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_EN    = EN;
  localparam logic [1:0] ST_SERVE = SERVE;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        state;
  logic [CNT_W-1:0]  served;
  logic [7:0]        org_row;
  logic [6:0]        org_col_word;
  logic              req_fire;
  logic              req_reject;
  logic [CALC_W-1:0] rd_addr_full;
  logic [ADDR_W-1:0] rd_addr;
  pixel_word_t       ram_rdata;

  assign req_ready = (state == ST_IDLE);
  assign en        = (state == ST_EN);
  assign busy      = (state != ST_IDLE);
  assign req_fire  = req_valid & req_ready;

  assign rd_addr_full = (CALC_W'(org_row) + CALC_W'(row)) * CALC_W'(FRAME_WORDS)
                      + CALC_W'(org_col_word) + CALC_W'(col);

`ifdef FWS_BOUNDS_CHECK_EN
  logic req_oob;
  logic rd_oob;
  logic err_r;

  assign req_oob = ((10'(req_row) + 10'(WIN_ROWS)) > 10'(FRAME_ROWS))
                 | ((10'(req_col_word) + 10'(WIN_WORDS)) > 10'(FRAME_WORDS));
  assign req_reject = req_fire & req_oob;

  assign rd_oob = (row >= 7'(WIN_ROWS)) | (col >= 7'(WIN_WORDS))
                | (rd_addr_full >= CALC_W'(FRAME_SIZE));
  assign rd_addr    = rd_oob ? '0 : ADDR_W'(rd_addr_full);
  assign input_data = rd_oob ? 32'd0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= req_reject;
    end
  end
  assign err = err_r;
`else
  assign req_reject = 1'b0;
  // Origins outside the frame wrap around instead of being rejected.
  assign rd_addr    = ADDR_W'(rd_addr_full % CALC_W'(FRAME_SIZE));
  assign input_data = ram_rdata;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      served       <= '0;
      org_row      <= '0;
      org_col_word <= '0;
      win_done     <= 1'b0;
    end else begin
      win_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_fire && !req_reject) begin
            state        <= ST_EN;
            org_row      <= req_row;
            org_col_word <= req_col_word;
          end
        end
        ST_EN: begin
          if (ack) begin
            state  <= ST_SERVE;
            served <= '0;
          end
        end
        ST_SERVE: begin
          // An early done cuts the window short; the loader owns the patch count.
          if (done) begin
            state    <= ST_IDLE;
            win_done <= 1'b1;
          end else if (served == LAST_WORD) begin
            state <= ST_DRAIN;
          end else begin
            served <= served + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (done) begin
            state    <= ST_IDLE;
            win_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fws_frame_ram #(
    .DEPTH  (FRAME_SIZE),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_frame_word_server.sv
// tb/tb_frame_word_server.sv - randomized scoreboard bench for frame_word_server
module tb_frame_word_server;
  import fws_pkg::*;

  localparam int FW   = 80;
  localparam int FR   = 240;
  localparam int FSZ  = FR * FW;
  localparam int NWIN = 1600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_row = '0;
  logic [6:0]  req_col_word = '0;
  logic        req_ready, en, busy, win_done, err;
  logic        ack = 1'b0;
  logic        done = 1'b0;
  logic [6:0]  row = '0;
  logic [6:0]  col = '0;
  logic [31:0] input_data;

  always #5 clk = ~clk;

  frame_word_server dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_row(req_row), .req_col_word(req_col_word),
    .req_ready(req_ready), .en(en), .ack(ack), .row(row), .col(col),
    .input_data(input_data), .done(done), .busy(busy), .win_done(win_done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int serve_seen = 0;
  logic [31:0] ref_mem [FSZ];
  int m_org_row = 0;
  int m_org_col = 0;
  logic [31:0] rd_q[$];
  int wd_q[$];
  int err_q[$];
  logic rd_strobe = 1'b0;
  logic [31:0] exp_word;
  int exp_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (dut.state == SERVE) serve_seen++;
    if (rd_strobe) begin
      if (rd_q.size() == 0) fail("rd_q_underflow", input_data, 0);
      else begin
        exp_word = rd_q.pop_front();
        check("input_data", input_data, exp_word);
      end
    end
    if (win_done === 1'b1) begin
      if (wd_q.size() == 0) fail("unexpected_win_done", cyc, 0);
      else begin
        exp_cyc = wd_q.pop_front();
        check("win_done_cycle", cyc, exp_cyc);
      end
    end
    if (err === 1'b1) begin
      if (err_q.size() == 0) fail("unexpected_err", cyc, 0);
      else begin
        exp_cyc = err_q.pop_front();
        check("err_cycle", cyc, exp_cyc);
      end
    end
  end

  function automatic int model_addr(input int r, input int c);
    return (m_org_row + r) * FW + m_org_col + c;
  endfunction

  function automatic logic [31:0] model_read(input int r, input int c);
    int a;
    a = model_addr(r, c);
`ifdef FWS_BOUNDS_CHECK_EN
    if (r >= WIN_ROWS || c >= WIN_WORDS || a >= FSZ) return 32'd0;
    return ref_mem[a];
`else
    return ref_mem[a % FSZ];
`endif
  endfunction

  function automatic int pick_row();
    if ($urandom_range(0, 99) < 90) return $urandom_range(0, WIN_ROWS - 1);
    return $urandom_range(0, 127);
  endfunction

  function automatic int pick_col();
    if ($urandom_range(0, 99) < 90) return $urandom_range(0, WIN_WORDS - 1);
    return $urandom_range(0, 127);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input int r, input int c);
    row = 7'(r);
    col = 7'(c);
    rd_q.push_back(model_read(r, c));
    rd_strobe = 1'b1;
  endtask

  // Called after drive_read so a same-cycle read of the written word expects the old value.
  task automatic maybe_write(input int r, input int c);
    int a;
    logic [31:0] d;
    wr_en = 1'b0;
    if ($urandom_range(0, 7) == 0) begin
      if ($urandom_range(0, 1) == 0) a = model_addr(r, c) % FSZ;
      else a = $urandom_range(0, FSZ - 1);
      if (a != 407 && a != 19199) begin
        d = $urandom;
        wr_en = 1'b1;
        wr_addr = 15'(a);
        wr_data = d;
        ref_mem[a] = d;
      end
    end
  endtask

  task automatic start_window(input int r, input int c);
    int en_cnt;
    int guard;
    req_valid = 1'b1;
    req_row = 8'(r);
    req_col_word = 7'(c);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    m_org_row = r;
    m_org_col = c;
    en_cnt = 0;
    guard = 0;
    while (en_cnt < 3 && guard < 10) begin
      done = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
      if (en === 1'b1) en_cnt++;
      ack = (en_cnt == 3);
      tick();
      ack = 1'b0;
      done = 1'b0;
    end
    check("en_cycles_before_ack", en_cnt, 3);
    serve_seen = 0;
  endtask

  task automatic serve(input int n, input bit hold_req);
    int bad_ready;
    int bad_en;
    int r;
    int c;
    bad_ready = 0;
    bad_en = 0;
    for (int k = 0; k < n; k++) begin
      r = pick_row();
      c = pick_col();
      drive_read(r, c);
      maybe_write(r, c);
      if (hold_req) begin
        req_valid = 1'b1;
        req_row = 8'($urandom);
        req_col_word = 7'($urandom);
      end
      @(negedge clk);
      if (hold_req && req_ready !== 1'b0) bad_ready++;
      if (en !== 1'b0 || busy !== 1'b1) bad_en++;
      tick();
    end
    rd_strobe = 1'b0;
    wr_en = 1'b0;
    req_valid = 1'b0;
    check("serve_busy_no_en", bad_en, 0);
    if (hold_req) check("hold_req_ready_low", bad_ready, 0);
  endtask

  task automatic finish_window();
    done = 1'b1;
    wd_q.push_back(cyc + 1);
    tick();
    done = 1'b0;
    @(negedge clk);
    check("idle_after_done_busy", 32'(busy), 0);
    check("idle_after_done_ready", 32'(req_ready), 1);
    tick();
  endtask

  task automatic directed_read(input string name, input int r, input int c, input logic [31:0] exp);
    drive_read(r, c);
    @(negedge clk);
    check(name, input_data, exp);
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic idle_reads(input int n);
    int r;
    int c;
    for (int k = 0; k < n; k++) begin
      r = pick_row();
      c = pick_col();
      drive_read(r, c);
      maybe_write(r, c);
      @(negedge clk);
      tick();
    end
    rd_strobe = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic random_window();
    int r;
    int c;
    int k;
`ifdef FWS_BOUNDS_CHECK_EN
    r = $urandom_range(0, FR - WIN_ROWS);
    c = $urandom_range(0, FW - WIN_WORDS);
`else
    r = $urandom_range(0, 255);
    c = $urandom_range(0, 127);
`endif
    start_window(r, c);
    if ($urandom_range(0, 1) == 0) begin
      k = $urandom_range(1, NWIN - 1);
      serve(k, 1'b0);
      check("serve_len_early", serve_seen, k);
    end else begin
      serve(NWIN + $urandom_range(1, 5), 1'b0);
      check("serve_len_full", serve_seen, NWIN);
    end
    finish_window();
  endtask

  initial begin
    tick();
    tick();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_en", 32'(en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_win_done", 32'(win_done), 0);
    check("rst_err", 32'(err), 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < FSZ; i++) begin
      wr_en = 1'b1;
      wr_addr = 15'(i);
      wr_data = i;
      ref_mem[i] = i;
      tick();
    end
    wr_en = 1'b0;

    // done while idle must be ignored
    done = 1'b1;
    tick();
    done = 1'b0;
    @(negedge clk);
    check("done_idle_ignored", 32'(busy), 0);
    tick();

    // Far-corner window, ended early by done
    start_window(160, 60);
    directed_read("t2_corner_word", 79, 19, 32'd19199);
    serve(500, 1'b0);
    check("t2_serve_len", serve_seen, 501);
    finish_window();

    // Origin (0,0): full window, write-while-read on word 407
    start_window(0, 0);
    directed_read("t1_r5c7", 5, 7, 32'd407);
    drive_read(5, 7);
    wr_en = 1'b1;
    wr_addr = 15'd407;
    wr_data = 32'hDEADBEEF;
    ref_mem[407] = 32'hDEADBEEF;
    @(negedge clk);
    check("t4_old_word", input_data, 32'd407);
    tick();
    wr_en = 1'b0;
    directed_read("t4_new_word", 5, 7, 32'hDEADBEEF);
    serve(NWIN - 3 + $urandom_range(1, 4), 1'b0);
    check("t1_serve_len", serve_seen, NWIN);
    finish_window();

    // Request held during SERVE is not taken and the origin stays put
    start_window(40, 30);
    serve(300, 1'b0);
    serve(400, 1'b1);
    serve(NWIN - 700 + 2, 1'b0);
    check("t3_serve_len", serve_seen, NWIN);
    finish_window();

    random_window();
    random_window();

    // Reset in the middle of SERVE
    start_window(20, 10);
    serve(100, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_org_row = 0;
    m_org_col = 0;
    @(negedge clk);
    check("t5_en", 32'(en), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_req_ready", 32'(req_ready), 1);
    tick();
    idle_reads(40);
    directed_read("t5_frame_kept", 5, 7, 32'hDEADBEEF);

`ifdef FWS_BOUNDS_CHECK_EN
    req_valid = 1'b1;
    req_row = 8'd200;
    req_col_word = 7'd0;
    @(negedge clk);
    check("t6_req_ready", 32'(req_ready), 1);
    err_q.push_back(cyc + 1);
    tick();
    req_row = 8'd0;
    req_col_word = 7'd61;
    err_q.push_back(cyc + 1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(busy), 0);
    tick();
    @(negedge clk);
    check("t6_still_idle", 32'(busy), 0);
    tick();
    start_window(160, 60);
    directed_read("t6_col25_zero", 0, 25, 32'd0);
    serve(50, 1'b0);
    finish_window();
`endif

    random_window();
    tick();
    tick();
    check("rd_q_drained", rd_q.size(), 0);
    check("wd_q_drained", wd_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
